// File: rtl/io_bus_arbiter.sv
// Two-master arbiter and single-beat sequencer for the processor I/O bus.
// Optional build macro: IO_ARB_FIXED_PRIO_EN (m0 always wins simultaneous requests).
module io_bus_arbiter #(
  parameter int unsigned ADDR_W   = 32,
  parameter int unsigned DATA_W   = 32,
  parameter int unsigned READ_LAT = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              m0_req,
  input  logic              m0_we,
  input  logic [ADDR_W-1:0] m0_addr,
  input  logic [DATA_W-1:0] m0_wdata,
  output logic              m0_gnt,
  output logic              m0_done,
  output logic [DATA_W-1:0] m0_rdata,
  input  logic              m1_req,
  input  logic              m1_we,
  input  logic [ADDR_W-1:0] m1_addr,
  input  logic [DATA_W-1:0] m1_wdata,
  output logic              m1_gnt,
  output logic              m1_done,
  output logic [DATA_W-1:0] m1_rdata,
  output logic [ADDR_W-1:0] io_address,
  output logic [DATA_W-1:0] io_write_value,
  output logic              io_write_en,
  output logic              io_read_en,
  input  logic [DATA_W-1:0] io_read_value
);

  localparam int unsigned CNT_W = 4;

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_DONE} state_t;

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              last_owner_q, last_owner_d;
  logic              owner_q, owner_d;
  logic              we_q, we_d;
  logic              winner_c;
  logic              to_done_c;
  logic              sample_c;
  logic [ADDR_W-1:0] addr_d;
  logic [DATA_W-1:0] wdata_d;
  logic [DATA_W-1:0] rdata0_d, rdata1_d;
  logic              gnt0_d, gnt1_d;
  logic              done0_d, done1_d;
  logic              wr_en_d, rd_en_d;

  // Winner selection; only consulted when at least one request is pending.
`ifdef IO_ARB_FIXED_PRIO_EN
  assign winner_c = ~m0_req;
`else
  assign winner_c = (m0_req & m1_req) ? ~last_owner_q : m1_req;
`endif

  // Next-state and next-output decode; every output is registered from these values.
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    last_owner_d = last_owner_q;
    owner_d      = owner_q;
    we_d         = we_q;
    addr_d       = io_address;
    wdata_d      = io_write_value;
    gnt0_d       = m0_gnt;
    gnt1_d       = m1_gnt;
    wr_en_d      = 1'b0;
    rd_en_d      = 1'b0;
    to_done_c    = 1'b0;
    sample_c     = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (m0_req || m1_req) begin
          state_d      = S_ISSUE;
          owner_d      = winner_c;
          last_owner_d = winner_c;
          we_d         = winner_c ? m1_we    : m0_we;
          addr_d       = winner_c ? m1_addr  : m0_addr;
          wdata_d      = winner_c ? m1_wdata : m0_wdata;
          wr_en_d      = we_d;
          rd_en_d      = ~we_d;
          gnt0_d       = ~winner_c;
          gnt1_d       = winner_c;
        end
      end
      S_ISSUE: begin
        if (we_q) begin
          to_done_c = 1'b1;
        end else if (READ_LAT <= 1) begin
          sample_c  = 1'b1;
          to_done_c = 1'b1;
        end else begin
          cnt_d   = CNT_W'(READ_LAT - 1);
          state_d = S_WAIT;
        end
      end
      S_WAIT: begin
        cnt_d = cnt_q - CNT_W'(1);
        if (cnt_q == CNT_W'(1)) begin
          sample_c  = 1'b1;
          to_done_c = 1'b1;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
        addr_d  = '0;
        wdata_d = '0;
        gnt0_d  = 1'b0;
        gnt1_d  = 1'b0;
      end
      default: state_d = S_IDLE;
    endcase

    if (to_done_c) state_d = S_DONE;

    done0_d  = to_done_c & ~owner_q;
    done1_d  = to_done_c & owner_q;
    rdata0_d = (sample_c & ~owner_q) ? io_read_value : m0_rdata;
    rdata1_d = (sample_c & owner_q)  ? io_read_value : m1_rdata;
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  // Latched transfer context and registered bus/master outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q          <= '0;
      last_owner_q   <= 1'b1;
      owner_q        <= 1'b0;
      we_q           <= 1'b0;
      io_address     <= '0;
      io_write_value <= '0;
      io_write_en    <= 1'b0;
      io_read_en     <= 1'b0;
      m0_gnt         <= 1'b0;
      m1_gnt         <= 1'b0;
      m0_done        <= 1'b0;
      m1_done        <= 1'b0;
      m0_rdata       <= '0;
      m1_rdata       <= '0;
    end else begin
      cnt_q          <= cnt_d;
      last_owner_q   <= last_owner_d;
      owner_q        <= owner_d;
      we_q           <= we_d;
      io_address     <= addr_d;
      io_write_value <= wdata_d;
      io_write_en    <= wr_en_d;
      io_read_en     <= rd_en_d;
      m0_gnt         <= gnt0_d;
      m1_gnt         <= gnt1_d;
      m0_done        <= done0_d;
      m1_done        <= done1_d;
      m0_rdata       <= rdata0_d;
      m1_rdata       <= rdata1_d;
    end
  end

endmodule

// File: tb/tb_io_bus_arbiter.sv
// Scoreboard bench for io_bus_arbiter: main instance at READ_LAT=2, plus directed
// READ_LAT=1 and READ_LAT=4 (mid-transfer reset) instances.
module tb_io_bus_arbiter;

  localparam int unsigned RL = 2;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  logic l4_rst_n = 1'b1;
  always #5 clk = ~clk;

  // Main instance signals.
  logic        m0_req = 1'b0, m0_we = 1'b0, m1_req = 1'b0, m1_we = 1'b0;
  logic [31:0] m0_addr = '0, m0_wdata = '0, m1_addr = '0, m1_wdata = '0;
  logic        m0_gnt, m0_done, m1_gnt, m1_done, io_write_en, io_read_en;
  logic [31:0] m0_rdata, m1_rdata, io_address, io_write_value;
  logic [31:0] io_read_value = 32'h0;

  // READ_LAT=1 instance (m0 only).
  logic        l1_m0_req = 1'b0, l1_m0_we = 1'b0;
  logic [31:0] l1_m0_addr = '0;
  logic        l1_m0_gnt, l1_m0_done, l1_m1_gnt, l1_m1_done, l1_io_write_en, l1_io_read_en;
  logic [31:0] l1_m0_rdata, l1_m1_rdata, l1_io_address, l1_io_write_value, l1_rv;

  // READ_LAT=4 instance (m1 only, own reset).
  logic        l4_m1_req = 1'b0, l4_m1_we = 1'b0;
  logic [31:0] l4_m1_addr = '0;
  logic        l4_m0_gnt, l4_m0_done, l4_m1_gnt, l4_m1_done, l4_io_write_en, l4_io_read_en;
  logic [31:0] l4_m0_rdata, l4_m1_rdata, l4_io_address, l4_io_write_value, l4_rv;

  assign l1_rv = l1_io_read_en ? 32'hA5A5_A5A5 : 32'h0;
  assign l4_rv = 32'h5555_0000;

  io_bus_arbiter #(.ADDR_W(32), .DATA_W(32), .READ_LAT(RL)) dut (
    .clk(clk), .rst_n(rst_n),
    .m0_req(m0_req), .m0_we(m0_we), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
    .m0_gnt(m0_gnt), .m0_done(m0_done), .m0_rdata(m0_rdata),
    .m1_req(m1_req), .m1_we(m1_we), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
    .m1_gnt(m1_gnt), .m1_done(m1_done), .m1_rdata(m1_rdata),
    .io_address(io_address), .io_write_value(io_write_value),
    .io_write_en(io_write_en), .io_read_en(io_read_en), .io_read_value(io_read_value));

  io_bus_arbiter #(.ADDR_W(32), .DATA_W(32), .READ_LAT(1)) u_l1 (
    .clk(clk), .rst_n(rst_n),
    .m0_req(l1_m0_req), .m0_we(l1_m0_we), .m0_addr(l1_m0_addr), .m0_wdata(32'h0),
    .m0_gnt(l1_m0_gnt), .m0_done(l1_m0_done), .m0_rdata(l1_m0_rdata),
    .m1_req(1'b0), .m1_we(1'b0), .m1_addr(32'h0), .m1_wdata(32'h0),
    .m1_gnt(l1_m1_gnt), .m1_done(l1_m1_done), .m1_rdata(l1_m1_rdata),
    .io_address(l1_io_address), .io_write_value(l1_io_write_value),
    .io_write_en(l1_io_write_en), .io_read_en(l1_io_read_en), .io_read_value(l1_rv));

  io_bus_arbiter #(.ADDR_W(32), .DATA_W(32), .READ_LAT(4)) u_l4 (
    .clk(clk), .rst_n(l4_rst_n),
    .m0_req(1'b0), .m0_we(1'b0), .m0_addr(32'h0), .m0_wdata(32'h0),
    .m0_gnt(l4_m0_gnt), .m0_done(l4_m0_done), .m0_rdata(l4_m0_rdata),
    .m1_req(l4_m1_req), .m1_we(l4_m1_we), .m1_addr(l4_m1_addr), .m1_wdata(32'h0),
    .m1_gnt(l4_m1_gnt), .m1_done(l4_m1_done), .m1_rdata(l4_m1_rdata),
    .io_address(l4_io_address), .io_write_value(l4_io_write_value),
    .io_write_en(l4_io_write_en), .io_read_en(l4_io_read_en), .io_read_value(l4_rv));

  typedef struct { logic owner; logic we; logic [31:0] addr; logic [31:0] wdata; } iss_t;
  typedef struct { logic owner; logic we; logic [31:0] rdata; } done_t;

  iss_t        iss_q[$];
  done_t       done_q[$];
  iss_t        iss_e;
  done_t       done_e;
  logic [31:0] exp_rd [2] = '{32'h0, 32'h0};
  logic [31:0] act_rd;
  int          n_tests = 0;
  int          n_fail = 0;
  int          cyc = 0;
  int          last_iss_cyc = -100;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] slave_mem(input logic [31:0] a);
    case (a)
      32'h200: return 32'h1234_5678;
      32'h204: return 32'h8765_4321;
      32'h300: return 32'hCAFE_F00D;
      default: return 32'h0;
    endcase
  endfunction

  // Slave for the main instance: valid data only in the cycle it must be sampled.
  logic [31:0] sl_addr = '0;
  int          sl_left = 0;
  logic        sl_act = 1'b0;
  always @(negedge clk) begin
    io_read_value = 32'hBAAD_F00D;
    if (io_read_en) begin
      sl_addr = io_address;
      sl_left = int'(RL) - 1;
      sl_act  = 1'b1;
    end else if (sl_act) begin
      sl_left--;
    end
    if (sl_act && sl_left == 0) begin
      io_read_value = slave_mem(sl_addr);
      sl_act = 1'b0;
    end
  end

  // Monitor: pops the scoreboard whenever the bus issues or a master sees done.
  always @(negedge clk) begin
    cyc++;
    if (rst_n) begin
      check("gnt_onehot", 32'(m0_gnt & m1_gnt), 32'd0);
      if (io_write_en || io_read_en) begin
        if (iss_q.size() == 0) begin
          check("unexpected_issue", 32'({io_write_en, io_read_en}), 32'd0);
        end else begin
          iss_e = iss_q.pop_front();
          check("strobe_excl", 32'(io_write_en & io_read_en), 32'd0);
          check("issue_we", 32'(io_write_en), 32'(iss_e.we));
          check("issue_addr", io_address, iss_e.addr);
          if (iss_e.we) check("issue_wdata", io_write_value, iss_e.wdata);
          check("issue_gnt", 32'({m1_gnt, m0_gnt}), iss_e.owner ? 32'd2 : 32'd1);
          if (last_iss_cyc >= 0)
            check("issue_spacing", (cyc - last_iss_cyc >= 3) ? 32'd1 : 32'd0, 32'd1);
          last_iss_cyc = cyc;
        end
      end
      if (m0_done || m1_done) begin
        if (done_q.size() == 0) begin
          check("unexpected_done", 32'({m1_done, m0_done}), 32'd0);
        end else begin
          done_e = done_q.pop_front();
          check("done_owner", 32'({m1_done, m0_done}), done_e.owner ? 32'd2 : 32'd1);
          check("done_latency", 32'(cyc - last_iss_cyc), done_e.we ? 32'd1 : 32'(RL));
          act_rd = done_e.owner ? m1_rdata : m0_rdata;
          if (done_e.we) begin
            check("rdata_held", act_rd, exp_rd[done_e.owner]);
          end else begin
            check("rdata", act_rd, done_e.rdata);
            exp_rd[done_e.owner] = done_e.rdata;
          end
        end
      end
    end
  end

  // Single transfer on the main instance; drop_after>0 drops req that many cycles after raising it.
  task automatic xfer(input logic m, input logic we, input logic [31:0] addr,
                      input logic [31:0] wdata, input logic [31:0] rdata, input int drop_after);
    logic seen = 1'b0;
    iss_q.push_back(iss_t'{m, we, addr, wdata});
    done_q.push_back(done_t'{m, we, rdata});
    @(negedge clk);
    if (!m) begin m0_req = 1'b1; m0_we = we; m0_addr = addr; m0_wdata = wdata; end
    else    begin m1_req = 1'b1; m1_we = we; m1_addr = addr; m1_wdata = wdata; end
    for (int k = 1; k <= 30 && !seen; k++) begin
      @(negedge clk);
      if (k == drop_after) begin m0_req = 1'b0; m1_req = 1'b0; end
      if ((!m && m0_done) || (m && m1_done)) seen = 1'b1;
    end
    check("xfer_done_seen", 32'(seen), 32'd1);
    m0_req = 1'b0;
    m1_req = 1'b0;
  endtask

  // Both masters write continuously for four transfers.
  task automatic contend();
    int         dones = 0;
    logic [3:0] owners;
`ifdef IO_ARB_FIXED_PRIO_EN
    owners = 4'b0000;
`else
    owners = 4'b1010;
`endif
    for (int k = 0; k < 4; k++) begin
      iss_q.push_back(iss_t'{owners[k], 1'b1, owners[k] ? 32'h20 : 32'h10,
                             owners[k] ? 32'h2222_0002 : 32'h1111_0001});
      done_q.push_back(done_t'{owners[k], 1'b1, 32'h0});
    end
    @(negedge clk);
    m0_req = 1'b1; m0_we = 1'b1; m0_addr = 32'h10; m0_wdata = 32'h1111_0001;
    m1_req = 1'b1; m1_we = 1'b1; m1_addr = 32'h20; m1_wdata = 32'h2222_0002;
    for (int t = 0; t < 40 && dones < 4; t++) begin
      @(negedge clk);
      if (m0_done || m1_done) dones++;
    end
    check("contend_done_count", 32'(dones), 32'd4);
    m0_req = 1'b0;
    m1_req = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish (t=%0t)", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    #2;
    rst_n = 1'b0;
    l4_rst_n = 1'b0;
    #1;
    check("rst_main_out", 32'(|{m0_gnt, m0_done, m0_rdata, m1_gnt, m1_done, m1_rdata,
                                io_address, io_write_value, io_write_en, io_read_en}), 32'd0);
    repeat (3) @(negedge clk);
    check("rst_main_clocked", 32'(|{m0_gnt, m1_gnt, io_address, io_write_en, io_read_en}), 32'd0);
    check("rst_l1_out", 32'(|{l1_m0_gnt, l1_m0_done, l1_m0_rdata, l1_m1_gnt, l1_m1_done, l1_m1_rdata,
                              l1_io_address, l1_io_write_value, l1_io_write_en, l1_io_read_en}), 32'd0);
    rst_n = 1'b1;
    l4_rst_n = 1'b1;

    xfer(1'b0, 1'b1, 32'h100, 32'hDEAD_BEEF, 32'h0, 0);
    xfer(1'b1, 1'b0, 32'h200, 32'h0, 32'h1234_5678, 0);
    contend();
    xfer(1'b0, 1'b0, 32'h300, 32'h0, 32'hCAFE_F00D, 0);
    xfer(1'b1, 1'b0, 32'h204, 32'h0, 32'h8765_4321, 2);
    repeat (4) begin
      @(negedge clk);
      check("idle_no_grant", 32'({m0_gnt, m1_gnt, io_write_en, io_read_en}), 32'd0);
    end

    // READ_LAT=1 read with combinational slave.
    @(negedge clk);
    l1_m0_req = 1'b1; l1_m0_we = 1'b0; l1_m0_addr = 32'h4;
    @(negedge clk);
    check("l1_issue", 32'({l1_io_read_en, l1_m0_gnt, l1_m0_done}), 32'b110);
    check("l1_issue_addr", l1_io_address, 32'h4);
    @(negedge clk);
    check("l1_done", 32'(l1_m0_done), 32'd1);
    check("l1_rdata", l1_m0_rdata, 32'hA5A5_A5A5);
    l1_m0_req = 1'b0;
    @(negedge clk);
    check("l1_done_pulse", 32'(l1_m0_done), 32'd0);

    // READ_LAT=4 read aborted by reset in WAIT, then re-issued.
    @(negedge clk);
    l4_m1_req = 1'b1; l4_m1_we = 1'b0; l4_m1_addr = 32'h40;
    @(negedge clk);
    check("l4_issue", 32'({l4_io_read_en, l4_m1_gnt}), 32'b11);
    repeat (2) @(negedge clk);
    check("l4_wait", 32'({l4_m1_gnt, l4_io_read_en, l4_io_write_en}), 32'b100);
    check("l4_wait_addr", l4_io_address, 32'h40);
    l4_rst_n = 1'b0;
    #1;
    check("l4_rst_abort", 32'(|{l4_m0_gnt, l4_m0_done, l4_m0_rdata, l4_m1_gnt, l4_m1_done, l4_m1_rdata,
                                l4_io_address, l4_io_write_value, l4_io_write_en, l4_io_read_en}), 32'd0);
    repeat (3) begin
      @(negedge clk);
      check("l4_rst_nodone", 32'({l4_m1_done, l4_m1_gnt, l4_io_read_en}), 32'd0);
    end
    l4_rst_n = 1'b1;
    @(negedge clk);
    check("l4_reissue", 32'({l4_io_read_en, l4_m1_gnt}), 32'b11);
    repeat (3) begin
      @(negedge clk);
      check("l4_no_early_done", 32'(l4_m1_done), 32'd0);
    end
    @(negedge clk);
    check("l4_done", 32'(l4_m1_done), 32'd1);
    check("l4_rdata", l4_m1_rdata, 32'h5555_0000);
    l4_m1_req = 1'b0;

    repeat (4) @(negedge clk);
    check("iss_q_empty", 32'(iss_q.size()), 32'd0);
    check("done_q_empty", 32'(done_q.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
